// File: rtl/present_pkg.sv
// Shared types and playfield geometry for the falling-present sprite.
package present_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FALL   = 2'd1,
      HIT    = 2'd2,
      MISSED = 2'd3
   } stateT;

   localparam int unsigned LANE_W      = 160;
   localparam int unsigned SPRITE_SIZE = 108;
   localparam int unsigned X_OFFSET    = 26;
   localparam int unsigned SCREEN_H    = 480;
   localparam int unsigned Y_MAX       = SCREEN_H - SPRITE_SIZE;
   localparam int unsigned CS_MOD      = 12;

   // Left edge of a sprite centred in one of the four 160-pixel lanes.
   function automatic logic [9:0] laneX(input logic [1:0] lane);
      return 10'(LANE_W * lane + X_OFFSET);
   endfunction

endpackage

// File: rtl/frame_tick_sync.sv
// Brings the VGA vsync level into the Clk domain and emits a one-cycle tick per frame.
module frame_tick_sync (
   input  logic Clk,
   input  logic Reset,
   input  logic frameIn,
   output logic tick
);

   logic frameSync_p0, frameSync_p1, frameSync_p2;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         frameSync_p0 <= 1'b0;
         frameSync_p1 <= 1'b0;
         frameSync_p2 <= 1'b0;
         tick         <= 1'b0;
      end else begin
         // _p0/_p1 form the synchronizer, _p2 holds the previous level for edge detection
         frameSync_p0 <= frameIn;
         frameSync_p1 <= frameSync_p0;
         frameSync_p2 <= frameSync_p1;
         tick         <= frameSync_p1 & ~frameSync_p2;
      end
   end

endmodule

// File: rtl/present_motion.sv
// Motion controller for one falling present: spawn, fall per frame tick, freeze on hit, report misses.
module present_motion
   import present_pkg::*;
#(
   parameter int unsigned HIT_HOLD  = 8,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_clk,
   input  logic       spawn,
   input  logic       hit,
   input  logic [2:0] speed,
   output logic [9:0] StartX,
   output logic [9:0] StartY,
   output logic [3:0] cs,
   output logic       randomColor,
   output logic       active,
   output logic       score_pulse,
   output logic       miss_pulse
);

   localparam int HOLD_W = ($clog2(HIT_HOLD) < 1) ? 1 : $clog2(HIT_HOLD);

   // A stalled speed setting of 0 still moves the sprite one pixel per frame.
   function automatic logic [10:0] stepOf(input logic [2:0] spd);
      return (spd == 3'd0) ? 11'd1 : {8'd0, spd};
   endfunction

   stateT             state, stateNext;
   logic              tick;
   logic [15:0]       lfsr;
   logic [HOLD_W-1:0] holdCnt, holdNext;
   logic [10:0]       yStep;
   logic [9:0]        xNext, yNext;
   logic [3:0]        csNext;
   logic              colorNext, scoreNext, missNext;

   frame_tick_sync uSync (
      .Clk     (Clk),
      .Reset   (Reset),
      .frameIn (frame_clk),
      .tick    (tick)
   );

   // Galois form of x^16 + x^14 + x^13 + x^11 + 1; never locks up as long as the seed is nonzero.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) lfsr <= LFSR_SEED;
      else       lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
   end

   assign yStep = {1'b0, StartY} + stepOf(speed);

   always_comb begin
      stateNext = state;
      xNext     = StartX;
      yNext     = StartY;
      csNext    = cs;
      colorNext = randomColor;
      holdNext  = holdCnt;
      scoreNext = 1'b0;
      missNext  = 1'b0;
      case (state)
         IDLE: if (spawn) begin
            stateNext = FALL;
            xNext     = laneX(lfsr[1:0]);
            yNext     = '0;
            colorNext = lfsr[2];
            csNext    = '0;
         end
         FALL: if (tick) begin
            // A hit wins over the bottom crossing on the same tick.
            if (hit) begin
               stateNext = HIT;
               scoreNext = 1'b1;
               holdNext  = '0;
            end else if (yStep > 11'(Y_MAX)) begin
               stateNext = MISSED;
               missNext  = 1'b1;
            end else begin
               yNext  = yStep[9:0];
               csNext = (cs == 4'(CS_MOD - 1)) ? 4'd0 : cs + 4'd1;
            end
         end
         HIT: if (tick) begin
            if (holdCnt == HOLD_W'(HIT_HOLD - 1)) begin
               stateNext = IDLE;
               holdNext  = '0;
            end else begin
               holdNext = holdCnt + HOLD_W'(1);
            end
         end
         MISSED:  stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state       <= IDLE;
         StartX      <= '0;
         StartY      <= '0;
         cs          <= '0;
         randomColor <= 1'b0;
         holdCnt     <= '0;
         active      <= 1'b0;
         score_pulse <= 1'b0;
         miss_pulse  <= 1'b0;
      end else begin
         state       <= stateNext;
         StartX      <= xNext;
         StartY      <= yNext;
         cs          <= csNext;
         randomColor <= colorNext;
         holdCnt     <= holdNext;
         active      <= (stateNext == FALL) || (stateNext == HIT);
         score_pulse <= scoreNext;
         miss_pulse  <= missNext;
      end
   end

endmodule

// File: tb/tb_present_motion.sv
// Directed bench for present_motion: falling, wrap, miss, hit hold, spawn filtering, reset abort.
module tb_present_motion;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic       frame_clk = 1'b0;
   logic       spawn = 1'b0;
   logic       hit = 1'b0;
   logic [2:0] speed = 3'd0;
   logic [9:0] StartX, StartY;
   logic [3:0] cs;
   logic       randomColor, active, score_pulse, miss_pulse;

   int nChecks = 0;
   int nFails  = 0;
   int scoreSeen = 0;
   int missSeen  = 0;
   int scoreBase, missBase;

   present_motion #(.HIT_HOLD(8), .LFSR_SEED(16'hACE1)) dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .frame_clk   (frame_clk),
      .spawn       (spawn),
      .hit         (hit),
      .speed       (speed),
      .StartX      (StartX),
      .StartY      (StartY),
      .cs          (cs),
      .randomColor (randomColor),
      .active      (active),
      .score_pulse (score_pulse),
      .miss_pulse  (miss_pulse)
   );

   always #5 Clk = ~Clk;

   always @(negedge Clk) begin
      if (score_pulse) scoreSeen++;
      if (miss_pulse)  missSeen++;
   end

   task automatic expectEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      if (obs !== exp) begin
         nFails++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic inLane(input logic [9:0] x);
      return (x == 10'd26) || (x == 10'd186) || (x == 10'd346) || (x == 10'd506);
   endfunction

   task automatic doReset();
      @(negedge Clk);
      Reset = 1'b1;
      repeat (2) @(negedge Clk);
      Reset = 1'b0;
      @(negedge Clk);
   endtask

   task automatic frameTick();
      frame_clk = 1'b1;
      repeat (6) @(negedge Clk);
      frame_clk = 1'b0;
      repeat (6) @(negedge Clk);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) frameTick();
   endtask

   task automatic spawnPulse();
      spawn = 1'b1;
      @(negedge Clk);
      spawn = 1'b0;
      @(negedge Clk);
   endtask

   initial begin
      // Reset values
      repeat (2) @(negedge Clk);
      expectEq("rst_x",     StartX, 0);
      expectEq("rst_y",     StartY, 0);
      expectEq("rst_cs",    cs, 0);
      expectEq("rst_color", randomColor, 0);
      expectEq("rst_active", active, 0);
      expectEq("rst_score", score_pulse, 0);
      expectEq("rst_miss",  miss_pulse, 0);
      Reset = 1'b0;
      @(negedge Clk);

      // Basic fall at speed 3
      speed = 3'd3;
      spawnPulse();
      expectEq("spawn_y", StartY, 0);
      expectEq("spawn_active", active, 1);
      ticks(5);
      expectEq("fall_y", StartY, 15);
      expectEq("fall_cs", cs, 5);
      expectEq("fall_active", active, 1);
      expectEq("fall_lane", inLane(StartX), 1);

      // Spawn during FALL is ignored
      for (int i = 0; i < 3; i++) spawnPulse();
      expectEq("respawn_y", StartY, 15);
      expectEq("respawn_cs", cs, 5);
      expectEq("respawn_lane", inLane(StartX), 1);
      ticks(1);
      expectEq("respawn_next_y", StartY, 18);

      // Speed 0 moves one pixel; cs wraps after 12 ticks
      doReset();
      speed = 3'd0;
      spawnPulse();
      ticks(11);
      expectEq("slow_cs11", cs, 11);
      ticks(1);
      expectEq("slow_y", StartY, 12);
      expectEq("slow_cs_wrap", cs, 0);

      // Bottom crossing at speed 7 produces a miss
      doReset();
      speed = 3'd7;
      spawnPulse();
      ticks(53);
      expectEq("deep_y", StartY, 371);
      expectEq("deep_cs", cs, 5);
      scoreBase = scoreSeen;
      missBase  = missSeen;
      ticks(1);
      expectEq("miss_count", missSeen - missBase, 1);
      expectEq("miss_no_score", scoreSeen - scoreBase, 0);
      expectEq("miss_active", active, 0);
      expectEq("idle_hold_y", StartY, 371);
      expectEq("idle_hold_cs", cs, 5);
      spawnPulse();
      expectEq("idle_spawn_y", StartY, 0);
      expectEq("idle_spawn_cs", cs, 0);
      expectEq("idle_spawn_active", active, 1);

      // Hit on the crossing tick wins; sprite freezes for 8 ticks
      doReset();
      speed = 3'd5;
      spawnPulse();
      ticks(74);
      expectEq("hitpos_y", StartY, 370);
      expectEq("hitpos_cs", cs, 2);
      scoreBase = scoreSeen;
      missBase  = missSeen;
      hit = 1'b1;
      repeat (5) @(negedge Clk);
      hit = 1'b0;
      @(negedge Clk);
      expectEq("hit_no_tick_score", scoreSeen - scoreBase, 0);
      expectEq("hit_no_tick_active", active, 1);
      speed = 3'd7;
      hit = 1'b1;
      ticks(1);
      hit = 1'b0;
      expectEq("hit_score", scoreSeen - scoreBase, 1);
      expectEq("hit_no_miss", missSeen - missBase, 0);
      expectEq("hit_active", active, 1);
      expectEq("hit_y", StartY, 370);
      ticks(7);
      expectEq("hold7_active", active, 1);
      expectEq("hold7_y", StartY, 370);
      expectEq("hold7_cs", cs, 2);
      ticks(1);
      expectEq("hold8_active", active, 0);
      expectEq("hold8_y", StartY, 370);
      expectEq("hold_no_miss", missSeen - missBase, 0);

      // Reset asserted while in HIT clears everything immediately
      doReset();
      speed = 3'd4;
      spawnPulse();
      ticks(2);
      hit = 1'b1;
      ticks(1);
      hit = 1'b0;
      ticks(2);
      expectEq("pre_abort_active", active, 1);
      expectEq("pre_abort_y", StartY, 8);
      scoreBase = scoreSeen;
      missBase  = missSeen;
      @(negedge Clk);
      #1 Reset = 1'b1;
      #1;
      expectEq("abort_x", StartX, 0);
      expectEq("abort_y", StartY, 0);
      expectEq("abort_cs", cs, 0);
      expectEq("abort_color", randomColor, 0);
      expectEq("abort_active", active, 0);
      expectEq("abort_score", score_pulse, 0);
      expectEq("abort_miss", miss_pulse, 0);
      repeat (3) @(negedge Clk);
      Reset = 1'b0;
      ticks(1);
      expectEq("abort_no_pulses", (scoreSeen - scoreBase) + (missSeen - missBase), 0);
      expectEq("abort_stays_idle", active, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
